// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low 7-segment pattern constants, capture FSM states and anode helper.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} cap_state_t;

    function automatic logic an_valid(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: active-low segment pattern -> BCD/hex value, blank and error flags.
// Hex letters A..F decode only when SEG7_CAP_HEX_EN is defined.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] val,
    output logic       blank,
    output logic       err
);
    always_comb begin
        val = 4'd0;
        blank = seg == SEG_BLANK;
        err = 1'b0;
        case (seg)
            SEG_0: val = 4'd0;
            SEG_1: val = 4'd1;
            SEG_2: val = 4'd2;
            SEG_3: val = 4'd3;
            SEG_4: val = 4'd4;
            SEG_5: val = 4'd5;
            SEG_6: val = 4'd6;
            SEG_7: val = 4'd7;
            SEG_8: val = 4'd8;
            SEG_9: val = 4'd9;
`ifdef SEG7_CAP_HEX_EN
            SEG_A: val = 4'd10;
            SEG_B: val = 4'd11;
            SEG_C: val = 4'd12;
            SEG_D: val = 4'd13;
            SEG_E: val = 4'd14;
            SEG_F: val = 4'd15;
`endif
            default: err = ~blank;
        endcase
    end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed active-low 7-segment bus and rebuilds 4-digit frames.
// Define SEG7_CAP_HEX_EN to also decode hex letters A..F.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT_W  = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic [3:0] an_in,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [3:0] blank,
    output logic [3:0] dp_out,
    output logic [3:0] digit_err,
    output logic       frame_pulse,
    output logic       frame_valid,
    output logic       stale
);
    localparam int SW = $clog2(SETTLE_CYC) + 1;

    logic [11:0] sync1, s, s_prev;
    logic [SW-1:0] stab_cnt;
    logic [TIMEOUT_W-1:0] to_cnt;
    cap_state_t state;
    logic [3:0] cur_an, mask, cap_mask, dig [4];
    logic [3:0] dec_val;
    logic dec_blank, dec_err, capture;

    wire [3:0] s_an  = s[11:8];
    wire [6:0] s_seg = s[7:1];
    wire       s_dp  = s[0];

    seg7_dec u_dec (.seg(s_seg), .val(dec_val), .blank(dec_blank), .err(dec_err));

    // s==s_prev guards against capturing a sample that changed on the very edge the count matured
    assign capture  = state == SETTLE && an_valid(s_an) && stab_cnt == SW'(SETTLE_CYC - 1) && s == s_prev;
    assign cap_mask = capture ? ~s_an : 4'h0;
    assign {d3, d2, d1, d0} = {dig[3], dig[2], dig[1], dig[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s <= '0;
            s_prev <= '0;
            stab_cnt <= '0;
            state <= IDLE;
            cur_an <= 4'hF;
            blank <= '0;
            dp_out <= '0;
            digit_err <= '0;
            for (int i = 0; i < 4; i++) dig[i] <= '0;
        end else begin
            sync1 <= {an_in, seg_in, dp_in};
            s <= sync1;
            s_prev <= s;
            stab_cnt <= s != s_prev ? '0 : &stab_cnt ? stab_cnt : stab_cnt + 1'b1;
            case (state)
                IDLE: if (an_valid(s_an)) state <= SETTLE;
                SETTLE: begin
                    if (!an_valid(s_an)) state <= IDLE;
                    else if (capture) begin
                        state <= HOLD;
                        cur_an <= s_an;
                    end
                end
                HOLD: if (s_an != cur_an) state <= an_valid(s_an) ? SETTLE : IDLE;
                default: state <= IDLE;
            endcase
            for (int i = 0; i < 4; i++) begin
                if (cap_mask[i]) begin
                    dig[i] <= dec_val;
                    blank[i] <= dec_blank;
                    dp_out[i] <= ~s_dp;
                    digit_err[i] <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
            frame_pulse <= 1'b0;
            frame_valid <= 1'b0;
            stale <= 1'b1;
            to_cnt <= '0;
        end else begin
            frame_pulse <= mask == 4'hF;
            mask <= (mask == 4'hF ? 4'h0 : mask) | cap_mask;
            to_cnt <= frame_pulse ? '0 : &to_cnt ? to_cnt : to_cnt + 1'b1;
            if (mask == 4'hF) begin
                frame_valid <= 1'b1;
                stale <= 1'b0;
            end else if (&to_cnt && !frame_pulse) begin
                frame_valid <= 1'b0;
                stale <= 1'b1;
            end
        end
    end
endmodule
